// File: rtl/mul_stream_pkg.sv
// Shared state encoding and sizing helpers for the word-serial multiplier
// front/back end (mul2048_stream_if and mul_result_serializer).
package mul_stream_pkg;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    WAIT,
    DRAIN
  } state_t;

  function automatic int num_words(input int data_width, input int word_width);
    return data_width / word_width;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_result_serializer.sv
// Captures the 2*DATA_WIDTH product and streams it out LSW first, one
// WORD_WIDTH word per advance, flagging the final word.
module mul_result_serializer
  import mul_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 2048,
  parameter int WORD_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    capture,
  input  logic [2*DATA_WIDTH-1:0] product,
  input  logic                    advance,
  output logic [WORD_WIDTH-1:0]   word,
  output logic                    last
);

  localparam int NR  = 2 * num_words(DATA_WIDTH, WORD_WIDTH);
  localparam int RCW = cnt_width(NR);
  localparam logic [RCW-1:0] R_LAST = RCW'(NR - 1);

  logic [2*DATA_WIDTH-1:0] result;
  logic [RCW-1:0]          rcnt;

  // Shifting out leaves the register all-zero once the last word is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      rcnt   <= '0;
    end else if (capture) begin
      result <= product;
      rcnt   <= '0;
    end else if (advance) begin
      result <= result >> WORD_WIDTH;
      rcnt   <= last ? '0 : rcnt + 1'b1;
    end
  end

  assign word = result[WORD_WIDTH-1:0];
  assign last = (rcnt == R_LAST);

endmodule

// File: rtl/mul2048_stream_if.sv
// Word-serial operand loader and result drainer around a fixed-latency multiplier.
// Optional completed-operation counter is enabled by defining MUL_STREAM_OPCNT_EN.
module mul2048_stream_if
  import mul_stream_pkg::*;
#(
  parameter int DATA_WIDTH  = 2048,
  parameter int WORD_WIDTH  = 64,
  parameter int MUL_LATENCY = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [WORD_WIDTH-1:0]   s_data,
  output logic [DATA_WIDTH-1:0]   mul_dat1,
  output logic [DATA_WIDTH-1:0]   mul_dat2,
  input  logic [2*DATA_WIDTH-1:0] mul_product,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [WORD_WIDTH-1:0]   m_data,
  output logic                    m_last,
  output logic                    busy,
  output logic [31:0]             op_count
);

  // state  | meaning
  // LOAD_A | shifting dat1 words in, LSW first
  // LOAD_B | shifting dat2 words in, LSW first
  // WAIT   | multiplier inputs held, counting pipeline latency
  // DRAIN  | product streaming out, LSW first

  localparam int NW  = num_words(DATA_WIDTH, WORD_WIDTH);
  localparam int WCW = cnt_width(NW);
  localparam int LCW = cnt_width(MUL_LATENCY);
  localparam logic [WCW-1:0] W_LAST = WCW'(NW - 1);
  localparam logic [LCW-1:0] L_LAST = LCW'(MUL_LATENCY - 1);

  state_t         state, state_nxt;
  logic [WCW-1:0] wcnt, wcnt_nxt;
  logic [LCW-1:0] lcnt, lcnt_nxt;
  logic           capture;
  logic           s_acc;
  logic           m_hs;
  logic           ser_last;
  logic           busy_nxt;

  assign s_acc = s_valid & s_ready;
  assign m_hs  = m_valid & m_ready;

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    lcnt_nxt  = lcnt;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    m_last    = 1'b0;
    capture   = 1'b0;
    case (state)
      LOAD_A: begin
        s_ready = ~rst;
        if (s_acc) begin
          if (wcnt == W_LAST) begin
            wcnt_nxt  = '0;
            state_nxt = LOAD_B;
          end else begin
            wcnt_nxt = wcnt + 1'b1;
          end
        end
      end
      LOAD_B: begin
        s_ready = ~rst;
        if (s_acc) begin
          if (wcnt == W_LAST) begin
            wcnt_nxt  = '0;
            lcnt_nxt  = '0;
            state_nxt = WAIT;
          end else begin
            wcnt_nxt = wcnt + 1'b1;
          end
        end
      end
      WAIT: begin
        // Capture lands on the MUL_LATENCY-th edge after the last operand word.
        if (lcnt == L_LAST) begin
          capture   = 1'b1;
          state_nxt = DRAIN;
        end else begin
          lcnt_nxt = lcnt + 1'b1;
        end
      end
      DRAIN: begin
        m_valid = 1'b1;
        m_last  = ser_last;
        if (m_ready && ser_last) state_nxt = LOAD_A;
      end
      default: state_nxt = LOAD_A;
    endcase
    busy_nxt = (state_nxt != LOAD_A) || (wcnt_nxt != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD_A;
      wcnt  <= '0;
      lcnt  <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      lcnt  <= lcnt_nxt;
      busy  <= busy_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_dat1 <= '0;
      mul_dat2 <= '0;
    end else if (s_acc) begin
      if (state == LOAD_A) mul_dat1 <= {s_data, mul_dat1[DATA_WIDTH-1:WORD_WIDTH]};
      else                 mul_dat2 <= {s_data, mul_dat2[DATA_WIDTH-1:WORD_WIDTH]};
    end
  end

  mul_result_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .WORD_WIDTH (WORD_WIDTH)
  ) u_ser (
    .clk     (clk),
    .rst     (rst),
    .capture (capture),
    .product (mul_product),
    .advance (m_hs),
    .word    (m_data),
    .last    (ser_last)
  );

`ifdef MUL_STREAM_OPCNT_EN
  logic [31:0] op_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                op_cnt <= '0;
    else if (m_hs && m_last) op_cnt <= op_cnt + 32'd1;
  end

  assign op_count = op_cnt;
`else
  assign op_count = '0;
`endif

endmodule

// File: tb/tb_mul2048_stream_if.sv
// Scoreboard bench for mul2048_stream_if with a fixed-latency multiplier model
// placed between mul_dat1/mul_dat2 and mul_product.
module tb_mul2048_stream_if;
  parameter int MUL_LATENCY = 4;
  localparam int DW = 2048;
  localparam int WW = 64;
  localparam int NW = DW / WW;
  localparam int NR = 2 * NW;
  localparam int PD = (MUL_LATENCY > 1) ? MUL_LATENCY - 1 : 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [WW-1:0] s_data = '0;
  logic [DW-1:0] mul_dat1, mul_dat2;
  logic [2*DW-1:0] mul_product, prod_comb;
  logic [2*DW-1:0] pipe [PD];
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [WW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic [31:0]   op_count;

  int errors = 0, checks = 0, cyc = 0, last_acc_edge = 0, exp_ops = 0;
  bit lat_pending = 0, rand_out = 0, held_v = 0, expect_ready = 0, prev_mv = 0;
  logic [WW-1:0] held_d;
  logic          held_l;
  logic [WW:0]   mon_e;
  logic [WW:0]   exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul2048_stream_if #(
    .DATA_WIDTH (DW),
    .WORD_WIDTH (WW),
    .MUL_LATENCY(MUL_LATENCY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .mul_dat1   (mul_dat1),
    .mul_dat2   (mul_dat2),
    .mul_product(mul_product),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy),
    .op_count   (op_count)
  );

  // Multiplier model: product of inputs stable before an edge is visible
  // MUL_LATENCY-1 edges later, so the DUT samples it on the MUL_LATENCY-th edge.
  assign prod_comb = {{DW{1'b0}}, mul_dat1} * {{DW{1'b0}}, mul_dat2};
  always @(posedge clk) begin
    pipe[0] <= prod_comb;
    for (int i = 1; i < PD; i++) pipe[i] <= pipe[i-1];
  end
  if (MUL_LATENCY == 1) begin : g_l1
    assign mul_product = prod_comb;
  end else begin : g_ln
    assign mul_product = pipe[MUL_LATENCY-2];
  end

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_op();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic push_op(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [2*DW-1:0] p;
    p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    for (int i = 0; i < NR; i++) exp_q.push_back({(i == NR - 1), p[i*WW +: WW]});
  endtask

  task automatic send_word(input logic [WW-1:0] w, input bit gaps);
    int n = 0;
    bit done = 0;
    while (!done) begin
      @(negedge clk);
      n++;
      s_valid = gaps ? 1'($urandom_range(1, 0)) : 1'b1;
      if (!s_ready) begin
        s_data = {$urandom, $urandom};
      end else begin
        s_data = w;
        done = s_valid;
      end
      if (!done && n > 4000) begin
        errors++;
        checks++;
        $display("FAIL send_timeout: no accept after %0d cycles", n);
        done = 1;
      end
    end
  endtask

  task automatic do_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit gaps);
    push_op(a, b);
    for (int i = 0; i < NW; i++) send_word(a[i*WW +: WW], gaps);
    for (int i = 0; i < NW; i++) send_word(b[i*WW +: WW], gaps);
    last_acc_edge = cyc + 1;
    lat_pending = 1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 6000) begin
      @(negedge clk);
      s_valid = 1'b0;
      n++;
    end
    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain_timeout: got %0d words outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Output monitor: owns m_ready, pops the scoreboard on each handshake.
  always @(negedge clk) begin
    if (rst) begin
      held_v = 0;
      expect_ready = 0;
      prev_mv = 0;
      exp_ops = 0;
    end else begin
      if (expect_ready) begin
        chk1("ready_after_last", s_ready, 1'b1);
        chk1("valid_after_last", m_valid, 1'b0);
        expect_ready = 0;
      end
      if (held_v) begin
        chk1("stall_valid", m_valid, 1'b1);
        chk("stall_data", m_data, held_d);
        chk1("stall_last", m_last, held_l);
      end
      if (m_valid && !prev_mv && lat_pending) begin
        chk("latency", 64'(cyc - last_acc_edge), 64'(MUL_LATENCY));
        lat_pending = 0;
      end
      if (m_valid) begin
        chk1("no_ready_in_drain", s_ready, 1'b0);
        chk1("busy_in_drain", busy, 1'b1);
      end
      m_ready = rand_out ? 1'($urandom_range(1, 0)) : 1'b1;
      held_v = 0;
      if (m_valid) begin
        if (m_ready) begin
          if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_word: got %h expected no output", m_data);
          end else begin
            mon_e = exp_q.pop_front();
            chk("m_data", m_data, mon_e[WW-1:0]);
            chk1("m_last", m_last, mon_e[WW]);
            if (mon_e[WW]) begin
              expect_ready = 1;
              exp_ops++;
            end
          end
        end else begin
          held_v = 1;
          held_d = m_data;
          held_l = m_last;
        end
      end
      prev_mv = m_valid;
    end
  end

  task automatic check_reset_outputs();
    chk1("rst_s_ready", s_ready, 1'b0);
    chk1("rst_m_valid", m_valid, 1'b0);
    chk1("rst_m_last", m_last, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_m_data", m_data, '0);
    chk1("rst_dat1_nonzero", |mul_dat1, 1'b0);
    chk1("rst_dat2_nonzero", |mul_dat2, 1'b0);
    chk("rst_op_count", 64'(op_count), '0);
  endtask

  initial begin
    logic [DW-1:0] a, b;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;

    a = DW'(3); b = DW'(5);
    do_op(a, b, 0);
    wait_drain();
    chk1("busy_idle", busy, 1'b0);

    a = '1; b = '1;
    do_op(a, b, 0);
    wait_drain();

    rand_out = 1;
    repeat (4) begin
      do_op(rand_op(), rand_op(), 1);
      wait_drain();
    end
    rand_out = 0;

    // Abort during LOAD_B word 10; nothing from this op may appear.
    a = rand_op(); b = rand_op();
    for (int i = 0; i < NW; i++) send_word(a[i*WW +: WW], 0);
    for (int i = 0; i < 10; i++) send_word(b[i*WW +: WW], 0);
    @(negedge clk);
    s_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;

    a = DW'(7); b = DW'(9);
    do_op(a, b, 0);
    wait_drain();

    a = DW'(2); b = DW'(3);
    do_op(a, b, 0);
    a = DW'(4); b = DW'(5);
    do_op(a, b, 0);
    wait_drain();
`ifdef MUL_STREAM_OPCNT_EN
    chk("op_count", 64'(op_count), 64'(exp_ops));
`else
    chk("op_count", 64'(op_count), '0);
`endif

    a = DW'(11); b = DW'(13);
    do_op(a, b, 0);
    wait_drain();
    chk1("busy_final", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
